reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_rd_port.sv | 77 +++++++
 rtl/reg_file_mp.sv | 152 +++++++++++++++
 tb/tb_reg_file_mp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-read-port register file: default widths
// and the encoding of the CLEAR/IDLE controller state.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  // Default geometry: 32 registers of 32 bits, two read ports.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD     = 2;

  // Controller state. CLEAR walks every entry writing zero; IDLE serves
  // normal reads and writes.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ctrl_state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
// One registered read port of the register file. Selects between the stored
// entry and the in-flight write data (write-first bypass), forces address 0 to
// zero when the zero register is enabled, and registers the result.
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, clears rd_data and rd_valid
//   busy      : file is clearing; reads are suppressed
//   rd_en     : read strobe for this port
//   rd_addr   : read address for this port
//   mem_data  : storage content at rd_addr
//   wr_en     : write strobe already qualified by the controller
//   wr_addr   : write address
//   wr_data   : write data
//   rd_data   : registered read data (holds when no read is accepted)
//   rd_valid  : one-cycle flag marking rd_data as freshly updated
// -----------------------------------------------------------------------------
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  busy,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic                  bypass_hit;
  logic                  zero_hit;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_value;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bypass_hit = wr_en && (wr_addr == rd_addr);
    zero_hit   = (ZERO_REG != 0) && (rd_addr == '0);
    rd_value   = mem_data;
    if (bypass_hit) begin
      rd_value = wr_data;
    end
    // The zero mask is applied last so it also wins over a bypassed write
    // aimed at address 0.
    if (zero_hit) begin
      rd_value = '0;
    end
  end

  assign rd_accept = rd_en && !busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_value;
      end
    end
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Register file with one write port and NUM_RD registered read ports. After
// reset, or on clr_req while idle, a clear sequence writes zero to every entry,
// one per cycle, while busy is high. Reads and writes are locked out during
// the clear, so no stale content is ever observable.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset; restarts the clear from entry 0
//   rd_en    : per-port read strobes
//   rd_addr  : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  : packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid : per-port one-cycle flag for freshly updated rd_data
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   clr_req  : pulse requesting a clear of the whole file (ignored while busy)
//   busy     : high while the clear sequence runs
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Clear controller
  // ---------------------------------------------------------------------------
  ctrl_state_e           state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_nxt;
      clr_ptr_q <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    clr_ptr_nxt = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        // The pointer wraps to 0 on the last step; by then the state is
        // IDLE, so the wrapped value never drives a write.
        clr_ptr_nxt = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == '1) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Storage and its single write process
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_accept;
  logic                  wr_zero_drop;

  // A user write is dropped during a clear and, with the zero register
  // enabled, when it targets address 0.
  assign wr_zero_drop = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_accept    = wr_en && !busy && !reset;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
      end else if (wr_en && !wr_zero_drop) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; its initial content is defined by
  // the clear sequence instead, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] port_addr;
    assign port_addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

    reg_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd_port (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy),
      .rd_en    (rd_en[g]),
      .rd_addr  (port_addr),
      .mem_data (mem[port_addr]),
      .wr_en    (wr_accept),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (rd_valid[g])
    );
  end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed bench for reg_file_mp. Two instances share all inputs: one with the
// zero register enabled (default) and one with it disabled.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data, rd_data_nz;
  logic [NR-1:0]      rd_valid, rd_valid_nz;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               clr_req;
  logic               busy, busy_nz;

  int n_checks = 0;
  int n_errors = 0;
  int n_busy;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nz), .rd_valid(rd_valid_nz), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_nz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
  endtask

  // Counts samples with busy high, starting at the current one; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_rd(2'b11, AW'(i), AW'(31 - i));
      tick();
      check({tag, "_data"},    rd_data,     64'h0);
      check({tag, "_data_nz"}, rd_data_nz,  64'h0);
      check({tag, "_valid"},   {62'h0, rd_valid}, 64'h3);
    end
    set_rd(2'b00, '0, '0);
  endtask

  initial begin
    reset   = 1'b1;
    clr_req = 1'b0;
    set_rd(2'b00, '0, '0);
    set_wr(1'b0, '0, '0);

    // Reset state
    tick();
    check("rst_busy",  {63'h0, busy},     64'h1);
    check("rst_valid", {62'h0, rd_valid}, 64'h0);
    check("rst_data",  rd_data,           64'h0);
    reset = 1'b0;

    // Reads during the initial clear are suppressed and never expose data
    set_rd(2'b11, 5'd3, 5'd4);
    tick();
    check("init_rd_valid", {62'h0, rd_valid}, 64'h0);
    check("init_rd_data",  rd_data,           64'h0);
    set_rd(2'b00, '0, '0);
    count_busy(n_busy);
    check("init_busy_len", 64'(n_busy + 1), 64'd32);
    check("init_busy_nz",  {63'h0, busy_nz}, 64'h0);
    read_all_zero("init_zero");

    // Write then dual read of the same address
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 5'd5, 5'd5);
    tick();
    check("wr5_data",  rd_data,           {32'hDEADBEEF, 32'hDEADBEEF});
    check("wr5_valid", {62'h0, rd_valid}, 64'h3);

    // No read strobe: data holds, valid drops
    set_rd(2'b00, 5'd1, 5'd2);
    tick();
    check("hold_data",  rd_data,           {32'hDEADBEEF, 32'hDEADBEEF});
    check("hold_valid", {62'h0, rd_valid}, 64'h0);

    // Same-cycle write/read bypass on port 1 only
    set_wr(1'b1, 5'd7, 32'h12345678);
    set_rd(2'b10, 5'd5, 5'd7);
    tick();
    check("byp_data",  rd_data,           {32'h12345678, 32'hDEADBEEF});
    check("byp_valid", {62'h0, rd_valid}, 64'h2);
    set_wr(1'b0, '0, '0);
    set_rd(2'b01, 5'd7, 5'd0);
    tick();
    check("byp_stored", rd_data,          {32'h12345678, 32'h12345678});
    check("byp_valid2", {62'h0, rd_valid}, 64'h1);

    // Distinct addresses on the two ports
    set_wr(1'b1, 5'd10, 32'h00001111);
    tick();
    set_wr(1'b1, 5'd11, 32'h22220000);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 5'd11, 5'd10);
    tick();
    check("dist_data", rd_data, {32'h00001111, 32'h22220000});

    // Zero register: write is discarded with ZERO_REG=1, kept with ZERO_REG=0
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(2'b00, '0, '0);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 5'd0, 5'd0);
    tick();
    check("zero_rd",    rd_data,    64'h0);
    check("nozero_rd",  rd_data_nz, {32'hFFFFFFFF, 32'hFFFFFFFF});
    // Simultaneous write and read of address 0
    set_wr(1'b1, 5'd0, 32'hA5A5A5A5);
    set_rd(2'b01, 5'd0, 5'd0);
    tick();
    set_wr(1'b0, '0, '0);
    check("zero_byp",   rd_data,    64'h0);
    check("nozero_byp", rd_data_nz, {32'hFFFFFFFF, 32'hA5A5A5A5});

    // Load known read data before clearing
    set_rd(2'b11, 5'd5, 5'd7);
    tick();
    set_rd(2'b00, '0, '0);

    // Clear via clr_req; a write and a second clr_req mid-clear are ignored
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy", {63'h0, busy}, 64'h1);
    repeat (9) tick();
    set_wr(1'b1, 5'd2, 32'hCAFEF00D);
    set_rd(2'b11, 5'd2, 5'd2);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    set_wr(1'b0, '0, '0);
    set_rd(2'b00, '0, '0);
    check("clr_rd_valid", {62'h0, rd_valid}, 64'h0);
    check("clr_rd_hold",  rd_data, {32'h12345678, 32'hDEADBEEF});
    count_busy(n_busy);
    check("clr_busy_len", 64'(n_busy + 10), 64'd32);
    set_rd(2'b11, 5'd2, 5'd5);
    tick();
    check("clr_wr_lost", rd_data, 64'h0);
    set_rd(2'b00, '0, '0);

    // Reset mid-clear restarts the clear from entry 0
    set_wr(1'b1, 5'd9, 32'h13579BDF);
    tick();
    set_wr(1'b0, '0, '0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    set_wr(1'b1, 5'd20, 32'h0BADF00D);
    set_rd(2'b11, 5'd9, 5'd9);
    tick();
    reset = 1'b0;
    check("mid_rst_busy",  {63'h0, busy},     64'h1);
    check("mid_rst_valid", {62'h0, rd_valid}, 64'h0);
    set_wr(1'b1, 5'd30, 32'h0BADF00D);
    set_rd(2'b00, '0, '0);
    count_busy(n_busy);
    set_wr(1'b0, '0, '0);
    check("mid_rst_len", 64'(n_busy), 64'd32);
    read_all_zero("mid_rst_zero");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule : tb_reg_file_mp
